// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: memOP codes, FSM states and
// the legality/alignment rules applied when an instruction is accepted.
package lsu_pkg;

   localparam int LANE_W = 8;
   localparam int LANES  = 4;

   localparam logic [2:0] OP_B  = 3'b000;
   localparam logic [2:0] OP_H  = 3'b001;
   localparam logic [2:0] OP_W  = 3'b010;
   localparam logic [2:0] OP_BU = 3'b100;
   localparam logic [2:0] OP_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   function automatic logic op_legal(input logic [2:0] op, input logic store);
      if (store)
         return (op == OP_B) || (op == OP_H) || (op == OP_W);
      return (op == OP_B) || (op == OP_H) || (op == OP_W) ||
             (op == OP_BU) || (op == OP_HU);
   endfunction

   function automatic logic misaligned(input logic [2:0] op, input logic [1:0] lo);
      case (op[1:0])
         2'b01:   return lo[0];
         2'b10:   return lo != 2'b00;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store data replication and write strobes, plus load
// byte/half extraction with sign or zero extension (memOP bit 2 = unsigned).
module lsu_align
   import lsu_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [2:0]        op,
   input  logic [1:0]        addr_lo,
   input  logic              store,
   input  logic [DATA_W-1:0] wdata,
   input  logic [DATA_W-1:0] rdata,
   output logic [DATA_W-1:0] st_wdata,
   output logic [LANES-1:0]  st_wmask,
   output logic [DATA_W-1:0] ld_data
);

   logic [DATA_W-1:0] shifted;
   logic [7:0]        byte_sel;
   logic [15:0]       half_sel;

   always_comb begin
      shifted  = rdata >> {addr_lo, 3'b000};
      byte_sel = shifted[7:0];
      half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
      st_wdata = wdata;
      st_wmask = '0;
      ld_data  = rdata;
      case (op[1:0])
         2'b00: begin
            st_wdata = {LANES{wdata[LANE_W-1:0]}};
            st_wmask = 4'b0001 << addr_lo;
            ld_data  = op[2] ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
         end
         2'b01: begin
            st_wdata = {2{wdata[15:0]}};
            st_wmask = 4'b0011 << addr_lo;
            ld_data  = op[2] ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
         end
         default: begin
            st_wdata = wdata;
            st_wmask = 4'b1111;
            ld_data  = rdata;
         end
      endcase
      if (!store)
         st_wmask = '0;
   end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one bus transaction per instruction over valid/ready,
// returning the extended load result (or an error) to writeback.
//
//   state   | meaning
//   IDLE    | ready for an instruction; decode legality on accept
//   REQ     | bus request held until mem_req_ready
//   WAIT    | request accepted, waiting for mem_resp_valid
//   DONE    | result presented until out_ready
module lsu
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [DATA_W-1:0] in_wdata,
   input  logic [2:0]        in_memOP,
   input  logic              in_wen,
   input  logic              in_ren,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_rdata,
   output logic              out_err,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_wen,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [3:0]        mem_wmask,
   input  logic              mem_resp_valid,
   input  logic [DATA_W-1:0] mem_resp_data,
   input  logic              mem_resp_err
);

   state_t            state, state_nx;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [2:0]        op_q;
   logic              wen_q, ren_q;
   logic [DATA_W-1:0] rdata_q, rdata_nx;
   logic              err_q, err_nx;
   logic [DATA_W-1:0] st_wdata, ld_data;
   logic [3:0]        st_wmask;

   lsu_align #(.DATA_W(DATA_W)) u_align (
      .op       (op_q),
      .addr_lo  (addr_q[1:0]),
      .store    (wen_q),
      .wdata    (wdata_q),
      .rdata    (mem_resp_data),
      .st_wdata (st_wdata),
      .st_wmask (st_wmask),
      .ld_data  (ld_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         op_q    <= '0;
         wen_q   <= 1'b0;
         ren_q   <= 1'b0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state   <= state_nx;
         rdata_q <= rdata_nx;
         err_q   <= err_nx;
         if (state == ST_IDLE && in_valid) begin
            addr_q  <= in_addr;
            wdata_q <= in_wdata;
            op_q    <= in_memOP;
            wen_q   <= in_wen;
            ren_q   <= in_ren;
         end
      end
   end

   always_comb begin
      state_nx = state;
      rdata_nx = rdata_q;
      err_nx   = err_q;
      case (state)
         ST_IDLE: begin
            if (in_valid) begin
               rdata_nx = '0;
               err_nx   = 1'b0;
               if (!in_wen && !in_ren) begin
                  state_nx = ST_DONE;
               end else if ((in_wen && in_ren) || !op_legal(in_memOP, in_wen) ||
                            misaligned(in_memOP, in_addr[1:0])) begin
                  state_nx = ST_DONE;
                  err_nx   = 1'b1;
               end else begin
                  state_nx = ST_REQ;
               end
            end
         end
         ST_REQ: begin
            if (mem_req_ready)
               state_nx = ST_WAIT;
         end
         ST_WAIT: begin
            if (mem_resp_valid) begin
               state_nx = ST_DONE;
               err_nx   = mem_resp_err;
               rdata_nx = (mem_resp_err || !ren_q) ? '0 : ld_data;
            end
         end
         ST_DONE: begin
            if (out_ready)
               state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // Strobes and write flag are qualified by REQ so the bus sees a clean idle.
   assign in_ready      = (state == ST_IDLE);
   assign out_valid     = (state == ST_DONE);
   assign mem_req_valid = (state == ST_REQ);
   assign mem_wen       = (state == ST_REQ) && wen_q;
   assign mem_wmask     = (state == ST_REQ) ? st_wmask : 4'b0000;
   assign mem_addr      = {addr_q[ADDR_W-1:2], 2'b00};
   assign mem_wdata     = st_wdata;
   assign out_rdata     = rdata_q;
   assign out_err       = err_q;

endmodule

// File: tb/tb_lsu.sv
// Randomized bench for lsu: a bus responder, a per-cycle compare process and a
// transaction-level reference model of the load/store rules.
module tb_lsu;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_addr = '0;
   logic [31:0] in_wdata = '0;
   logic [2:0]  in_memOP = '0;
   logic        in_wen = 1'b0;
   logic        in_ren = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_rdata;
   logic        out_err;
   logic        mem_req_valid;
   logic        mem_req_ready = 1'b0;
   logic [31:0] mem_addr;
   logic        mem_wen;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wmask;
   logic        mem_resp_valid = 1'b0;
   logic [31:0] mem_resp_data = '0;
   logic        mem_resp_err = 1'b0;

   always #5 clk = ~clk;

   lsu dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_addr        (in_addr),
      .in_wdata       (in_wdata),
      .in_memOP       (in_memOP),
      .in_wen         (in_wen),
      .in_ren         (in_ren),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_rdata      (out_rdata),
      .out_err        (out_err),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_addr       (mem_addr),
      .mem_wen        (mem_wen),
      .mem_wdata      (mem_wdata),
      .mem_wmask      (mem_wmask),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_data  (mem_resp_data),
      .mem_resp_err   (mem_resp_err)
   );

   int n_total = 0;
   int n_bad   = 0;

   // expected transaction (set by the driver before each instruction)
   logic [31:0] e_addr, e_rdata, e_reqdata;
   logic        e_wen, e_err, e_bus;
   logic [3:0]  e_mask;
   logic        inflight = 1'b0;
   // responder knobs
   int          k_stall = 0, k_delay = 0;
   logic [31:0] k_rdata = '0;
   logic        k_rerr = 1'b0;
   int          force_req = 0, force_ack = 0;
   // responder state
   bit          rsp_pend, in_req, last_req, last_rdy, hs;
   int          rsp_cnt, scnt;
   // monitor state
   int          hs_count = 0;
   bit          prev_req, prev_rdy;
   logic [31:0] cap_addr, cap_wdata;
   logic [3:0]  cap_mask;
   logic        cap_wen;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: what one instruction must do, from the architectural rules.
   function automatic void model(input logic [2:0] op, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic wen, input logic ren,
                                 input logic [31:0] rd, input logic rerr,
                                 output logic bus, output logic [31:0] r, output logic e,
                                 output logic [3:0] m, output logic [31:0] wd);
      int          n;
      bit          legal;
      logic [31:0] v;
      n = 1 << op[1:0];
      if (wen && !ren) legal = (op <= 3'd2);
      else             legal = (op != 3'd3) && (op < 3'd6);
      bus = 0; r = 0; e = 0; m = 0; wd = 0;
      if (!wen && !ren) begin
         e = 0;
      end else if ((wen && ren) || !legal || (addr % n) != 0) begin
         e = 1;
      end else begin
         bus = 1;
         if (wen) begin
            m  = 4'(((1 << n) - 1) << (addr % 4));
            wd = (n == 1) ? (wdata & 32'hFF) * 32'h01010101 :
                 (n == 2) ? (wdata & 32'hFFFF) * 32'h00010001 : wdata;
         end
         if (rerr) begin
            e = 1;
         end else if (ren) begin
            v = rd >> (8 * (addr % 4));
            if (n == 1) begin
               v = v & 32'hFF;
               if (op < 4 && v >= 128) v = v - 256;
            end else if (n == 2) begin
               v = v & 32'hFFFF;
               if (op < 4 && v >= 32768) v = v - 65536;
            end
            r = v;
         end
      end
   endfunction

   task automatic setup(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic wen, input logic ren, input int stall, input int delay,
                        input logic [31:0] rd, input logic rerr);
      model(op, addr, wdata, wen, ren, rd, rerr, e_bus, e_rdata, e_err, e_mask, e_reqdata);
      e_addr = addr; e_wen = wen;
      k_stall = stall; k_delay = delay; k_rdata = rd; k_rerr = rerr;
      in_memOP = op; in_addr = addr; in_wdata = wdata; in_wen = wen; in_ren = ren;
   endtask

   task automatic run(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic wen, input logic ren, input int stall, input int delay,
                      input int ostall, input logic [31:0] rd, input logic rerr,
                      output int lat, output logic [31:0] got_r, output logic got_e);
      int h0;
      chk("idle_in_ready", in_ready, 1);
      setup(op, addr, wdata, wen, ren, stall, delay, rd, rerr);
      h0 = hs_count;
      out_ready = 1'b0;
      inflight = 1'b1;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_wdata = $urandom; in_addr = $urandom;
      lat = 1;
      while (!out_valid && lat < 60) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("out_valid_timeout", out_valid, 1);
      got_r = out_rdata;
      got_e = out_err;
      chk("latency", lat, e_bus ? 3 + stall + delay : 1);
      repeat (ostall) begin
         @(posedge clk); #1;
         chk("hold_out_valid", out_valid, 1);
         chk("hold_in_ready", in_ready, 0);
         chk("hold_no_req", mem_req_valid, 0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      inflight = 1'b0;
      chk("released", out_valid, 0);
      chk("in_ready_after", in_ready, 1);
      chk("handshakes", hs_count - h0, {31'b0, e_bus});
   endtask

   initial begin
      int          lat;
      logic [31:0] r, tmp;
      logic        e;

      fork
         // bus responder: drives just after each rising edge
         forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
               rsp_pend = 0; in_req = 0; last_req = 0; last_rdy = 0;
               mem_req_ready = 0; mem_resp_valid = 0;
               continue;
            end
            hs = last_req && last_rdy;
            mem_resp_valid = 0;
            mem_resp_err   = 0;
            mem_resp_data  = $urandom;
            if (hs) begin
               rsp_pend = 1;
               rsp_cnt  = k_delay;
            end
            if (rsp_pend) begin
               if (rsp_cnt == 0) begin
                  mem_resp_valid = 1; mem_resp_data = k_rdata; mem_resp_err = k_rerr;
                  rsp_pend = 0;
               end else begin
                  rsp_cnt--;
               end
            end else if (force_req != force_ack) begin
               force_ack = force_req;
               mem_resp_valid = 1;
            end else if (!mem_req_valid && $urandom_range(0, 7) == 0) begin
               mem_resp_valid = 1;
               mem_resp_err   = 1'($urandom_range(0, 1));
            end
            if (mem_req_valid) begin
               if (!in_req) begin
                  in_req = 1;
                  scnt   = k_stall;
               end
               if (scnt == 0) mem_req_ready = 1;
               else begin
                  mem_req_ready = 0;
                  scnt--;
               end
            end else begin
               in_req = 0;
               mem_req_ready = 1'($urandom_range(0, 1));
            end
            last_req = mem_req_valid;
            last_rdy = mem_req_ready;
         end
         // compare process: samples on the falling edge
         forever begin
            @(negedge clk);
            if (!rst_n) begin
               prev_req = 0; prev_rdy = 0;
               continue;
            end
            if (mem_req_valid) begin
               chk("req_addr", mem_addr, {e_addr[31:2], 2'b00});
               chk("req_wen", mem_wen, e_wen);
               chk("req_mask", mem_wmask, e_mask);
               if (e_wen) chk("req_wdata", mem_wdata, e_reqdata);
               chk("req_in_ready", in_ready, 0);
               if (mem_req_ready) begin
                  hs_count++;
                  cap_addr = mem_addr; cap_wdata = mem_wdata;
                  cap_mask = mem_wmask; cap_wen = mem_wen;
               end
            end else begin
               chk("idle_wmask", mem_wmask, 0);
            end
            if (prev_req && !prev_rdy) chk("req_held", mem_req_valid, 1);
            if (out_valid) begin
               chk("out_rdata", out_rdata, e_rdata);
               chk("out_err", out_err, e_err);
               chk("out_in_ready", in_ready, 0);
            end
            if (!inflight) chk("spurious_out_valid", out_valid, 0);
            prev_req = mem_req_valid;
            prev_rdy = mem_req_ready;
         end
      join_none

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_req_valid", mem_req_valid, 0);
      chk("rst_wen", mem_wen, 0);
      chk("rst_wmask", mem_wmask, 0);
      chk("rst_rdata", out_rdata, 0);
      chk("rst_err", out_err, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_wdata", mem_wdata, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // directed cases with hand-computed results
      run(3'b010, 32'h80000004, 32'h0, 0, 1, 0, 0, 0, 32'hDEADBEEF, 0, lat, r, e);
      chk("lw_rdata", r, 32'hDEADBEEF);
      chk("lw_err", e, 0);
      chk("lw_addr", cap_addr, 32'h80000004);
      chk("lw_mask", cap_mask, 0);
      chk("lw_lat", lat, 3);

      run(3'b000, 32'h80000003, 32'h0, 0, 1, 0, 0, 0, 32'h80FF7F01, 0, lat, r, e);
      chk("lb_rdata", r, 32'hFFFFFF80);
      run(3'b100, 32'h80000003, 32'h0, 0, 1, 0, 0, 1, 32'h80FF7F01, 0, lat, r, e);
      chk("lbu_rdata", r, 32'h00000080);

      run(3'b001, 32'h80000002, 32'h1234ABCD, 1, 0, 0, 0, 0, 32'h0, 0, lat, r, e);
      tmp = cap_wdata;
      chk("sh_addr", cap_addr, 32'h80000000);
      chk("sh_mask", cap_mask, 4'b1100);
      chk("sh_wdata_hi", tmp[31:16], 16'hABCD);
      chk("sh_wen", cap_wen, 1);
      chk("sh_rdata", r, 0);

      run(3'b010, 32'h80000001, 32'h0, 0, 1, 0, 0, 0, 32'h0, 0, lat, r, e);
      chk("mis_lw_err", e, 1);
      chk("mis_lw_lat", lat, 1);
      run(3'b011, 32'h80000000, 32'h0, 0, 1, 0, 0, 0, 32'h0, 0, lat, r, e);
      chk("op011_err", e, 1);

      run(3'b010, 32'h80000008, 32'h0, 0, 1, 5, 1, 3, 32'h12345678, 1, lat, r, e);
      chk("buserr_err", e, 1);
      chk("buserr_rdata", r, 0);
      chk("buserr_lat", lat, 9);

      // reset while waiting for the response
      setup(3'b010, 32'h80000010, 32'h0, 0, 1, 0, 20, 32'hCAFEF00D, 0);
      inflight = 1'b1;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("pre_rst_no_out", out_valid, 0);
      #2 rst_n = 1'b0;
      #1;
      inflight = 1'b0;
      chk("arst_in_ready", in_ready, 1);
      chk("arst_out_valid", out_valid, 0);
      chk("arst_req_valid", mem_req_valid, 0);
      chk("arst_wen", mem_wen, 0);
      chk("arst_wmask", mem_wmask, 0);
      chk("arst_rdata", out_rdata, 0);
      chk("arst_err", out_err, 0);
      chk("arst_addr", mem_addr, 0);
      chk("arst_wdata", mem_wdata, 0);
      @(posedge clk); #3;
      rst_n = 1'b1;
      k_delay = 0;
      force_req++;
      repeat (6) begin
         @(posedge clk); #1;
         chk("post_rst_out_valid", out_valid, 0);
         chk("post_rst_req", mem_req_valid, 0);
      end

      // randomized traffic
      for (int i = 0; i < 300; i++) begin
         logic [2:0]  op;
         logic [31:0] addr;
         logic        wen, ren;
         int          kind;
         op   = 3'($urandom_range(0, 7));
         addr = $urandom;
         if ($urandom_range(0, 2) != 0) addr = addr & ~(32'((1 << op[1:0]) - 1));
         kind = $urandom_range(0, 9);
         wen  = (kind == 1) || (kind >= 6);
         ren  = (kind >= 1) && (kind <= 5);
         run(op, addr, $urandom, wen, ren, $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom, 1'($urandom_range(0, 7) == 0), lat, r, e);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
